// File: rtl/alu_seq_pkg.sv
// alu_seq_pkg: state encoding, header mark, status bit indices and opcodes shared by alu_seq
package alu_seq_pkg;
    typedef enum logic [2:0] {IDLE, GET_A, GET_B, EXEC, SEND_HI, SEND_LO, SEND_ST} state_t;
    localparam logic [4:0] HDR_MARK = 5'b10101;
    localparam int ST_DIV0 = 0;
    localparam int ST_TIMEOUT = 1;
    localparam logic [2:0] OP_DIV = 3'b011;
    localparam logic [2:0] OP_MOD = 3'b100;
endpackage

// File: rtl/alu_seq_timeout.sv
// alu_seq_timeout: inter-byte idle counter, strobes expired on the cycle it reaches TIMEOUT_CYCLES
module alu_seq_timeout #(
    parameter int TIMEOUT_CYCLES = 1000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic run,
    output logic expired
);
    localparam logic [15:0] LIMIT = 16'(TIMEOUT_CYCLES - 1);
    logic [15:0] cnt;
    always_ff @(posedge clk)
        if (!rst_n) cnt <= '0;
        else cnt <= clr ? '0 : run ? cnt + 16'd1 : cnt;
    // an accepted byte in the same cycle beats the timeout
    assign expired = (TIMEOUT_CYCLES != 0) && run && !clr && cnt == LIMIT;
endmodule

// File: rtl/alu_seq.sv
// alu_seq: 3-byte command frame sequencer feeding an 8-bit ALU; ALU_SEQ_STATUS_EN adds a status response byte
module alu_seq
    import alu_seq_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 1000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [7:0]  in_data,
    input  logic        in_valid,
    output logic        in_ready,
    output logic [7:0]  alu_a,
    output logic [7:0]  alu_b,
    output logic [2:0]  alu_opcode,
    output logic        alu_ena,
    input  logic [15:0] alu_result,
    output logic [7:0]  out_data,
    output logic        out_valid,
    input  logic        out_ready,
    output logic        err,
    output logic        busy
);
    state_t state, state_d;
    logic [15:0] result;
    logic in_fire, out_fire, hdr_ok, getting, expired;
    assign getting = state == GET_A || state == GET_B;
    assign in_ready = rst_n && (state == IDLE || getting);
    assign in_fire = in_valid && in_ready;
    assign out_valid = state == SEND_HI || state == SEND_LO || state == SEND_ST;
    assign out_fire = out_valid && out_ready;
    assign hdr_ok = in_data[7:3] == HDR_MARK;
    assign busy = state != IDLE;
    alu_seq_timeout #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_timeout (
        .clk(clk),
        .rst_n(rst_n),
        .clr(in_fire),
        .run(getting),
        .expired(expired)
    );
`ifdef ALU_SEQ_STATUS_EN
    localparam state_t LO_NEXT = SEND_ST;
    logic timeout_seen;
    logic [7:0] status;
    always_comb begin
        status = '0;
        status[ST_DIV0] = (alu_opcode == OP_DIV || alu_opcode == OP_MOD) && alu_b == 8'h00;
        status[ST_TIMEOUT] = timeout_seen;
    end
    always_ff @(posedge clk)
        if (!rst_n) timeout_seen <= 1'b0;
        else if (expired) timeout_seen <= 1'b1;
        else if (state == SEND_ST && out_fire) timeout_seen <= 1'b0;
    assign out_data = state == SEND_HI ? result[15:8] : state == SEND_LO ? result[7:0] :
                      state == SEND_ST ? status : 8'h00;
`else
    localparam state_t LO_NEXT = IDLE;
    assign out_data = state == SEND_HI ? result[15:8] : state == SEND_LO ? result[7:0] : 8'h00;
`endif
    always_ff @(posedge clk)
        if (!rst_n) state <= IDLE;
        else state <= state_d;
    always_comb begin
        state_d = state;
        case (state)
            IDLE:    if (in_fire && hdr_ok) state_d = GET_A;
            GET_A:   state_d = in_fire ? GET_B : expired ? IDLE : GET_A;
            GET_B:   state_d = in_fire ? EXEC : expired ? IDLE : GET_B;
            EXEC:    state_d = SEND_HI;
            SEND_HI: if (out_fire) state_d = SEND_LO;
            SEND_LO: if (out_fire) state_d = LO_NEXT;
            SEND_ST: if (out_fire) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end
    always_ff @(posedge clk)
        if (!rst_n) begin
            alu_a <= '0;
            alu_b <= '0;
            alu_opcode <= '0;
            alu_ena <= 1'b0;
            err <= 1'b0;
            result <= '0;
        end else begin
            alu_ena <= state == GET_B && in_fire;
            err <= (state == IDLE && in_fire && !hdr_ok) || expired;
            if (state == IDLE && in_fire && hdr_ok) alu_opcode <= in_data[2:0];
            if (state == GET_A && in_fire) alu_a <= in_data;
            if (state == GET_B && in_fire) alu_b <= in_data;
            if (state == EXEC) result <= alu_result;
        end
endmodule

// File: tb/tb_alu_seq.sv
// tb_alu_seq: directed and randomized frames against a behavioural ALU/frame reference
module tb_alu_seq;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [7:0]  in_data = 8'h00;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [7:0]  alu_a, alu_b;
    logic [2:0]  alu_opcode;
    logic        alu_ena;
    logic [15:0] alu_result;
    logic [7:0]  out_data;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic        err, busy;
    int checks = 0;
    int failures = 0;
    int ena_cnt = 0;
    logic ts = 1'b0;

    alu_seq #(.TIMEOUT_CYCLES(8)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
        .alu_a(alu_a), .alu_b(alu_b), .alu_opcode(alu_opcode), .alu_ena(alu_ena),
        .alu_result(alu_result),
        .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
        .err(err), .busy(busy)
    );

    always #5 clk = ~clk;

    // stand-in ALU and reference arithmetic: add, sub, mul, div, mod, and, or, xor
    function automatic logic [15:0] alu_ref(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b);
        int x = int'(a);
        int y = int'(b);
        int r;
        case (op)
            3'd0: r = x + y;
            3'd1: r = (x - y) & 255;
            3'd2: r = x * y;
            3'd3: r = (y == 0) ? 0 : x / y;
            3'd4: r = (y == 0) ? 0 : x % y;
            3'd5: r = x & y;
            3'd6: r = x | y;
            default: r = x ^ y;
        endcase
        return 16'(r);
    endfunction

    assign alu_result = alu_ref(alu_opcode, alu_a, alu_b);

    always @(posedge clk) if (alu_ena) ena_cnt <= ena_cnt + 1;

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic put(input logic [7:0] b);
        int n = 0;
        in_data = b;
        in_valid = 1'b1;
        while (!in_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("in_ready_wait", {15'b0, in_ready}, 16'd1);
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic get(input string tag, input logic [7:0] exp);
        int n = 0;
        int k = $urandom_range(0, 2);
        out_ready = 1'b0;
        while (!out_valid && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk({tag, "_valid"}, {15'b0, out_valid}, 16'd1);
        repeat (k) begin
            chk({tag, "_hold"}, {8'h00, out_data}, {8'h00, exp});
            @(negedge clk);
        end
        out_ready = 1'b1;
        chk(tag, {8'h00, out_data}, {8'h00, exp});
        @(negedge clk);
        out_ready = 1'b0;
    endtask

    task automatic frame(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b, input bit gaps);
        int e0 = ena_cnt;
        logic [15:0] r = alu_ref(op, a, b);
        if (gaps) repeat ($urandom_range(0, 3)) @(negedge clk);
        put({5'b10101, op});
        if (gaps) repeat ($urandom_range(0, 3)) @(negedge clk);
        put(a);
        if (gaps) repeat ($urandom_range(0, 3)) @(negedge clk);
        put(b);
        get("res_hi", r[15:8]);
        get("res_lo", r[7:0]);
`ifdef ALU_SEQ_STATUS_EN
        get("status", {6'b0, ts, (op == 3'd3 || op == 3'd4) && b == 8'h00});
        ts = 1'b0;
`endif
        chk("ena_pulses", 16'(ena_cnt - e0), 16'd1);
        chk("idle_after_frame", {15'b0, busy}, 16'd0);
    endtask

    task automatic bad_header(input logic [7:0] h);
        logic [2:0] op0 = alu_opcode;
        put(h);
        chk("bad_hdr_err", {15'b0, err}, 16'd1);
        chk("bad_hdr_idle", {15'b0, busy}, 16'd0);
        chk("bad_hdr_opcode_kept", {13'b0, alu_opcode}, {13'b0, op0});
        @(negedge clk);
        chk("bad_hdr_err_pulse", {15'b0, err}, 16'd0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog expired observed=running expected=finished");
        $fatal(1);
    end

    initial begin
        int e0;
        logic [7:0] ra, rb, bh;
        logic [2:0] rop;
        repeat (2) @(negedge clk);
        chk("rst_in_ready", {15'b0, in_ready}, 16'd0);
        chk("rst_out_valid", {15'b0, out_valid}, 16'd0);
        chk("rst_busy", {15'b0, busy}, 16'd0);
        chk("rst_err", {15'b0, err}, 16'd0);
        chk("rst_alu_ena", {15'b0, alu_ena}, 16'd0);
        chk("rst_alu_a", {8'h00, alu_a}, 16'd0);
        chk("rst_alu_b", {8'h00, alu_b}, 16'd0);
        chk("rst_alu_opcode", {13'b0, alu_opcode}, 16'd0);
        chk("rst_out_data", {8'h00, out_data}, 16'd0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("idle_in_ready", {15'b0, in_ready}, 16'd1);

        // add with out_ready tied high: exact cycle timing
        out_ready = 1'b1;
        e0 = ena_cnt;
        put(8'hA8);
        put(8'hFF);
        put(8'h01);
        chk("add_exec_ena", {15'b0, alu_ena}, 16'd1);
        chk("add_exec_no_valid", {15'b0, out_valid}, 16'd0);
        chk("add_alu_a", {8'h00, alu_a}, 16'h00FF);
        chk("add_alu_b", {8'h00, alu_b}, 16'h0001);
        @(negedge clk);
        chk("add_hi_valid", {15'b0, out_valid}, 16'd1);
        chk("add_ena_low", {15'b0, alu_ena}, 16'd0);
        chk("add_hi", {8'h00, out_data}, 16'h0001);
        @(negedge clk);
        chk("add_lo_valid", {15'b0, out_valid}, 16'd1);
        chk("add_lo", {8'h00, out_data}, 16'h0000);
`ifdef ALU_SEQ_STATUS_EN
        @(negedge clk);
        chk("add_st", {8'h00, out_data}, 16'h0000);
`endif
        @(negedge clk);
        chk("add_done_valid", {15'b0, out_valid}, 16'd0);
        chk("add_done_busy", {15'b0, busy}, 16'd0);
        chk("add_ena_once", 16'(ena_cnt - e0), 16'd1);
        out_ready = 1'b0;

        frame(3'd2, 8'hFF, 8'hFF, 1'b0);
        frame(3'd3, 8'h10, 8'h00, 1'b0);
        bad_header(8'h12);
        frame(3'd5, 8'h05, 8'h03, 1'b0);

        // timeout after the A byte
        put(8'hA8);
        put(8'h05);
        for (int i = 1; i <= 8; i++) begin
            chk("tmo_no_err_yet", {15'b0, err}, 16'd0);
            chk("tmo_busy", {15'b0, busy}, 16'd1);
            @(negedge clk);
        end
        chk("tmo_err", {15'b0, err}, 16'd1);
        chk("tmo_idle", {15'b0, busy}, 16'd0);
        ts = 1'b1;
        @(negedge clk);
        bad_header(8'h05);
        frame(3'd0, 8'h01, 8'h02, 1'b0);

        // backpressure in SEND_HI then reset
        put(8'hA9);
        put(8'h10);
        put(8'h03);
        @(negedge clk);
        for (int i = 0; i < 10; i++) begin
            chk("bp_valid", {15'b0, out_valid}, 16'd1);
            chk("bp_hold", {8'h00, out_data}, 16'h0000);
            chk("bp_in_ready", {15'b0, in_ready}, 16'd0);
            @(negedge clk);
        end
        rst_n = 1'b0;
        chk("rst_forces_in_ready", {15'b0, in_ready}, 16'd0);
        @(negedge clk);
        rst_n = 1'b1;
        chk("mid_rst_valid", {15'b0, out_valid}, 16'd0);
        chk("mid_rst_busy", {15'b0, busy}, 16'd0);
        chk("mid_rst_out_data", {8'h00, out_data}, 16'd0);
        chk("mid_rst_alu_a", {8'h00, alu_a}, 16'd0);
        out_ready = 1'b1;
        repeat (3) begin
            chk("no_stale_byte", {15'b0, out_valid}, 16'd0);
            @(negedge clk);
        end
        out_ready = 1'b0;
        ts = 1'b0;

        for (int i = 0; i < 30; i++) begin
            if ($urandom_range(0, 4) == 0) begin
                bh = 8'($urandom);
                while (bh[7:3] == 5'b10101) bh = 8'($urandom);
                bad_header(bh);
            end else begin
                rop = 3'($urandom);
                ra = 8'($urandom);
                rb = ($urandom_range(0, 3) == 0) ? 8'h00 : 8'($urandom);
                frame(rop, ra, rb, 1'b1);
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/alu_seq.md
# alu_seq

Byte-stream command sequencer that sits directly upstream of the 8-bit `ALU` and feeds it. It collects a 3-byte command frame (header/opcode, operand A, operand B) over a valid/ready input stream, drives the ALU operands with a one-cycle enable, captures the 16-bit result, and returns it as bytes on a valid/ready output stream. The host-side UART/SPI byte links connect to this block; the `ALU` instance hangs off its `alu_*` ports at top level.

## Interface
- `TIMEOUT_CYCLES`, default 1000: idle cycles allowed between operand bytes before the frame is aborted. Range 0..65535; 0 disables the timeout.
- `clk`  in  1  single clock; all logic on the rising edge.
- `rst_n`  in  1  synchronous, active-low reset.
- `in_data`  in  8  command byte stream.
- `in_valid`  in  1  `in_data` is valid.
- `in_ready`  out  1  block accepts `in_data` this cycle.
- `alu_a`  out  8  operand A to the ALU, registered.
- `alu_b`  out  8  operand B to the ALU, registered.
- `alu_opcode`  out  3  opcode to the ALU, registered.
- `alu_ena`  out  1  ALU enable, registered, high for exactly 1 cycle per frame.
- `alu_result`  in  16  combinational result from the ALU.
- `out_data`  out  8  response byte stream.
- `out_valid`  out  1  `out_data` is valid.
- `out_ready`  in  1  downstream accepts `out_data`.
- `err`  out  1  one-cycle pulse on a frame error (bad header or timeout).
- `busy`  out  1  high in any state other than IDLE.

## Operation
- Transfers on both streams: a beat is transferred when valid and ready are both 1 on a rising edge.
- Header byte: `[7:3]` must equal `HDR_MARK` = 5'b10101, so legal headers are 0xA8..0xAF. `[2:0]` is the opcode.
- States and transitions:
  - IDLE → GET_A on a legal header. The opcode is latched.
  - An illegal header byte is accepted and discarded, `err` pulses, and the block stays in IDLE.
  - GET_A → GET_B on a byte, which is latched as A.
  - GET_B → EXEC on a byte, which is latched as B.
  - EXEC → SEND_HI after exactly 1 cycle. `alu_ena` = 1 and `alu_result` is captured into the result register at the end of the cycle.
  - SEND_HI → SEND_LO on an output beat; `out_data` = result[15:8].
  - SEND_LO → IDLE on an output beat; `out_data` = result[7:0]. With `ALU_SEQ_STATUS_EN` the transition is SEND_LO → SEND_ST instead.
  - SEND_ST → IDLE on an output beat.
- `in_ready` = 1 only in IDLE, GET_A and GET_B, and is forced to 0 while `rst_n` = 0.
- `out_valid` = 1 only in the SEND_* states. `out_data` is held stable while `out_valid` = 1 and `out_ready` = 0.
- `alu_a`, `alu_b` and `alu_opcode` hold their last values after EXEC and update only on byte capture.
- Timeout:
  - A 16-bit counter clears on every accepted byte and increments each cycle in GET_A/GET_B.
  - When the counter reaches `TIMEOUT_CYCLES`, the state goes to IDLE and `err` pulses.
  - If a byte arrives in that same cycle, the byte wins and no timeout occurs.
  - There is no timeout in the SEND_* states; backpressure may stall the block indefinitely.
- Reset: `rst_n` low on any edge, including mid-frame or mid-send, forces IDLE. Every register output resets to 0: `alu_a`, `alu_b`, `alu_opcode`, `alu_ena`, `out_data`, `out_valid`, `err`, `busy`. A partial frame is discarded.

## Timing
- Header in cycle t0, A in t1, B in t2 (back-to-back input). EXEC runs in t3 and `out_valid` rises in t4.
- Latency from the B beat to the first `out_valid` is 2 cycles.
- With `out_ready` tied to 1, the response takes 2 cycles (3 cycles with status).
- IDLE is re-entered on the edge after the last output beat, and the next header can be accepted in that cycle.
- Peak throughput is one frame per 6 cycles (7 with status).

## Configuration
- `ALU_SEQ_STATUS_EN` defined: a third response byte is sent. Status = {6'b0, timeout_seen, div0}:
  - `div0` = 1 when the opcode is 3'b011 or 3'b100 and B = 0x00.
  - `timeout_seen` = 1 if the previous frame was aborted by timeout. It is cleared after its status byte is sent.
- `ALU_SEQ_STATUS_EN` undefined: the response is 2 bytes, the SEND_ST state and the status logic are absent, and the SEND_LO → IDLE transition applies.

## Structure
- Package `alu_seq_pkg` holds:
  - the state encoding (IDLE, GET_A, GET_B, EXEC, SEND_HI, SEND_LO, SEND_ST);
  - `HDR_MARK`;
  - status bit indices `ST_DIV0` = 0 and `ST_TIMEOUT` = 1;
  - the opcode constants `OP_DIV` = 3'b011 and `OP_MOD` = 3'b100.
- Sub-module `alu_seq_timeout` contains the load/clear/compare counter and emits a one-cycle `expired` strobe. The FSM and datapath stay in `alu_seq`.

## Test plan
- Add: bytes 0xA8, 0xFF, 0x01 with the ALU connected → output 0x01 then 0x00. `alu_ena` is high for exactly 1 cycle, and `out_valid` rises 2 cycles after the B beat.
- Multiply: 0xAA, 0xFF, 0xFF → 0xFE, 0x01.
- Divide by zero: 0xAB, 0x10, 0x00 → 0x00, 0x00. With `ALU_SEQ_STATUS_EN` a third byte 0x01 follows.
- Bad header: 0x12 → byte accepted, `err` pulses once, state stays IDLE. A following 0xAD, 0x05, 0x03 returns 0x00, 0x01.
- Timeout with `TIMEOUT_CYCLES` = 8: send 0xA8, 0x05, then idle → `err` pulses 8 cycles after the 0x05 beat. A next byte of 0x05 is then treated as a bad header.
- Backpressure and reset:
  - Hold `out_ready` = 0 for 10 cycles in SEND_HI → `out_data` is held, `in_ready` = 0.
  - Assert `rst_n` = 0 for 1 cycle in SEND_HI → `out_valid` = 0 and `busy` = 0 on the next edge; no stale byte appears after reset.
